// File: rtl/pow_seq_unit.sv
// pow_seq_unit
//   Sequential power unit: out = in^(s+1), computed by repeated multiplication,
//   one multiply per clock. Valid/ready handshake on both the operand side and
//   the result side. A sticky per-operation overflow flag reports whether any
//   product had bits above OUT_W.
//
// Parameters
//   IN_W    operand width (unsigned)
//   MODE_W  mode width; exponent = s+1, range 1..2^MODE_W
//   OUT_W   result width; exact when OUT_W >= IN_W*2^MODE_W
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand/mode offered
//   in_ready   unit can accept a new operation (idle)
//   in         base operand, sampled only at accept
//   s          mode, sampled only at accept; exponent = s+1
//   out_valid  result available, held until out_ready
//   out_ready  consumer takes the result
//   out        low OUT_W bits of in^(s+1)
//   ovf        some product of this operation exceeded OUT_W bits
//   busy       unit is not idle
module pow_seq_unit #(
  parameter int unsigned IN_W   = 3,
  parameter int unsigned MODE_W = 2,
  parameter int unsigned OUT_W  = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in,
  input  logic [MODE_W-1:0] s,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out,
  output logic              ovf,
  output logic              busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [OUT_W-1:0]       acc_q,   acc_d;
  logic [IN_W-1:0]        base_q,  base_d;
  logic [MODE_W-1:0]      cnt_q,   cnt_d;
  logic                   ovf_q,   ovf_d;
  logic [OUT_W+IN_W-1:0]  prod;

  // Full-width product; truncation happens only when it is written into acc.
  always_comb begin
    prod = {{IN_W{1'b0}}, acc_q} * {{OUT_W{1'b0}}, base_q};
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    base_d  = base_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          base_d  = in;
          acc_d   = OUT_W'(in);
          cnt_d   = s;
          ovf_d   = 1'b0;
          state_d = (s == '0) ? S_DONE : S_MUL;
        end
      end
      S_MUL: begin
        acc_d = prod[OUT_W-1:0];
        cnt_d = cnt_q - MODE_W'(1);
        ovf_d = ovf_q | (|prod[OUT_W+IN_W-1:OUT_W]);
        if (cnt_q == MODE_W'(1)) state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      base_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign out       = acc_q;
  assign ovf       = ovf_q;

endmodule
